bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_stream_reader_pkg.sv | 6 +
 rtl/bram_stream_if.sv | 26 ++
 rtl/bram_rd_fifo.sv | 36 +++
 rtl/bram_stream_reader.sv | 73 +++++++
 tb/tb_bram_stream_reader.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_reader_pkg: shared widths and FSM encoding for the BRAM stream reader
package bram_stream_reader_pkg;
    localparam int RAM_WIDTH_DEF  = 13;
    localparam int NB_ADDRESS_DEF = 10;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
endpackage

// File: rtl/bram_stream_if.sv
// bram_stream_if: burst request, memory read port and valid/ready stream of the reader
interface bram_stream_if
    import bram_stream_reader_pkg::*;
#(
    parameter int RAM_WIDTH  = RAM_WIDTH_DEF,
    parameter int NB_ADDRESS = NB_ADDRESS_DEF
);
    logic                  i_start;
    logic [NB_ADDRESS-1:0] i_baseAdd;
    logic [NB_ADDRESS:0]   i_length;
    logic [NB_ADDRESS-1:0] o_readAdd;
    logic [RAM_WIDTH-1:0]  i_bramData;
    logic [RAM_WIDTH-1:0]  o_data;
    logic                  o_valid;
    logic                  i_ready;
    logic                  o_busy;
    logic                  o_done;
    modport slave (
        input  i_start, i_baseAdd, i_length, i_bramData, i_ready,
        output o_readAdd, o_data, o_valid, o_busy, o_done
    );
    modport master (
        output i_start, i_baseAdd, i_length, i_bramData, i_ready,
        input  o_readAdd, o_data, o_valid, o_busy, o_done
    );
endinterface

// File: rtl/bram_rd_fifo.sv
// bram_rd_fifo: 2-entry FIFO buffering returned read data ahead of the stream port
module bram_rd_fifo
    import bram_stream_reader_pkg::*;
#(
    parameter int RAM_WIDTH = RAM_WIDTH_DEF
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 push,
    input  logic                 pop,
    input  logic [RAM_WIDTH-1:0] din,
    output logic [RAM_WIDTH-1:0] dout,
    output logic                 full,
    output logic                 empty
);
    logic [RAM_WIDTH-1:0] mem [2];
    logic                 wp, rp;
    logic [1:0]           cnt;
    assign full  = cnt == 2'd2;
    assign empty = cnt == 2'd0;
    assign dout  = mem[rp];
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) mem[wp] <= din;
            wp  <= wp ^ push;
            rp  <= rp ^ pop;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads a burst of consecutive BRAM words and streams them out with valid/ready
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int RAM_WIDTH  = RAM_WIDTH_DEF,
    parameter int NB_ADDRESS = NB_ADDRESS_DEF
) (
    input logic          i_CLK,
    input logic          i_RST,
    bram_stream_if.slave bus
);
    state_t                state;
    logic [NB_ADDRESS:0]   len, iss;
    logic [NB_ADDRESS-1:0] read_add;
    logic                  pend, busy, done, issue, last_iss, last_beat, pop, full, empty;
    logic [1:0]            cnt;
    assign cnt       = full ? 2'd2 : {1'b0, !empty};
    assign pop       = !empty && bus.i_ready;
    // a beat leaving this cycle frees its slot, so one read per cycle can stay in flight
    assign issue     = state == READ && ({1'b0, pend} + cnt < 2'd2 + {1'b0, pop});
    assign last_iss  = iss == len - (NB_ADDRESS+1)'(1);
    assign last_beat = state == DRAIN && pop && cnt == 2'd1 && !pend;
    assign bus.o_readAdd = read_add;
    assign bus.o_valid   = !empty;
    assign bus.o_busy    = busy;
    assign bus.o_done    = done;
    bram_rd_fifo #(.RAM_WIDTH(RAM_WIDTH)) u_fifo (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .push  (pend),
        .pop   (pop),
        .din   (bus.i_bramData),
        .dout  (bus.o_data),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state    <= IDLE;
            len      <= '0;
            iss      <= '0;
            read_add <= '0;
            pend     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            pend <= issue;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= bus.i_start;
                    done <= bus.i_start && bus.i_length == '0;
                    if (bus.i_start && bus.i_length != '0) begin
                        state    <= READ;
                        len      <= bus.i_length;
                        iss      <= '0;
                        read_add <= bus.i_baseAdd;
                    end
                end
                READ: if (issue) begin
                    iss      <= iss + (NB_ADDRESS+1)'(1);
                    state    <= last_iss ? DRAIN : READ;
                    read_add <= last_iss ? read_add : read_add + NB_ADDRESS'(1);
                end
                DRAIN: if (last_beat) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: table-driven and randomized bursts against a registered-read memory holding mem[a]=a
module tb_bram_stream_reader;
    typedef struct {
        int base;
        int len;
        int mode;
        int first;
        int last;
    } vec_t;
    logic        clk;
    logic        rst_n;
    logic [12:0] mem [1024];
    int          checks, errors, cyc, done_n, done_cyc, mode, pd;
    bit          noise;
    logic        pv, pr;
    int          got[$];
    int          gcyc[$];
    vec_t        tbl[7];
    bram_stream_if #(.RAM_WIDTH(13), .NB_ADDRESS(10)) bus ();
    bram_stream_reader #(.RAM_WIDTH(13), .NB_ADDRESS(10)) dut (
        .i_CLK (clk),
        .i_RST (rst_n),
        .bus   (bus)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) bus.i_bramData <= mem[bus.o_readAdd];
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask
    task automatic step();
        bit nz;
        @(posedge clk);
        #1;
        cyc++;
        bus.i_ready = mode == 0 ? 1'b1 : mode == 1 ? ~bus.i_ready : 1'($urandom_range(1));
        nz = noise && bus.o_busy && !bus.o_done && $urandom_range(3) == 0;
        bus.i_start = nz;
        if (nz) begin
            bus.i_baseAdd = 10'($urandom);
            bus.i_length  = 11'($urandom);
        end
        @(negedge clk);
        if (pv && !pr) chk("stall_hold", bus.o_valid ? int'(bus.o_data) : -1, pd);
        if (bus.o_valid && bus.i_ready) begin
            got.push_back(int'(bus.o_data));
            gcyc.push_back(cyc);
        end
        if (bus.o_done) begin
            done_n++;
            done_cyc = cyc;
        end
        pv = bus.o_valid;
        pr = bus.i_ready;
        pd = int'(bus.o_data);
    endtask
    task automatic clear();
        got.delete();
        gcyc.delete();
        done_n   = 0;
        done_cyc = -1;
        pv       = 1'b0;
    endtask
    task automatic run_burst(input int base, input int len, input int md, input int first, input int last);
        int s, n, bad;
        clear();
        mode          = md;
        bus.i_baseAdd = 10'(base);
        bus.i_length  = 11'(len);
        bus.i_ready   = 1'b1;
        bus.i_start   = 1'b1;
        step();
        s = cyc;
        n = 0;
        while (done_n == 0 && n < len * 4 + 20) begin
            step();
            n++;
        end
        chk("done_seen", done_n, 1);
        step();
        chk("busy_after_done", int'(bus.o_busy), 0);
        chk("done_once", done_n, 1);
        chk("beat_count", got.size(), len);
        bad = 0;
        foreach (got[i]) if (got[i] != (base + i) % 1024) bad++;
        chk("beat_model_mismatches", bad, 0);
        if (got.size() > 0) begin
            chk("first_beat", got[0], first);
            chk("last_beat", got[$], last);
            chk("done_after_last", done_cyc, gcyc[$] + 1);
            if (md == 0) begin
                chk("first_latency", gcyc[0] - s, 2);
                chk("throughput_span", gcyc[$] - gcyc[0], len - 1);
            end
        end else begin
            chk("done_zero_len", done_cyc, s);
        end
    endtask
    initial begin
        int n, b, l;
        checks = 0;
        errors = 0;
        cyc    = 0;
        mode   = 0;
        noise  = 1'b0;
        pv     = 1'b0;
        pr     = 1'b0;
        pd     = 0;
        for (int a = 0; a < 1024; a++) mem[a] = 13'(a);
        rst_n         = 1'b0;
        bus.i_start   = 1'b0;
        bus.i_baseAdd = '0;
        bus.i_length  = '0;
        bus.i_ready   = 1'b1;
        #22;
        chk("rst_valid", int'(bus.o_valid), 0);
        chk("rst_done", int'(bus.o_done), 0);
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_readadd", int'(bus.o_readAdd), 0);
        chk("rst_data", int'(bus.o_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tbl[0] = '{5, 4, 0, 5, 8};
        tbl[1] = '{1022, 4, 0, 1022, 1};
        tbl[2] = '{0, 8, 1, 0, 7};
        tbl[3] = '{9, 0, 0, 0, 0};
        tbl[4] = '{300, 1024, 0, 300, 299};
        tbl[5] = '{1023, 1, 0, 1023, 1023};
        tbl[6] = '{40, 5, 1, 40, 44};
        foreach (tbl[i]) run_burst(tbl[i].base, tbl[i].len, tbl[i].mode, tbl[i].first, tbl[i].last);
        noise = 1'b1;
        for (int k = 0; k < 8; k++) begin
            b = $urandom_range(1023);
            l = $urandom_range(40, 1);
            run_burst(b, l, 2, b, (b + l - 1) % 1024);
        end
        noise = 1'b0;
        clear();
        mode          = 0;
        bus.i_baseAdd = '0;
        bus.i_length  = 11'd10;
        bus.i_start   = 1'b1;
        step();
        n = 0;
        while (got.size() < 2 && n < 30) begin
            step();
            n++;
        end
        chk("abort_two_beats_seen", got.size(), 2);
        @(posedge clk);
        #2;
        chk("abort_third_beat_valid", int'(bus.o_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", int'(bus.o_valid), 0);
        chk("abort_busy", int'(bus.o_busy), 0);
        chk("abort_done", int'(bus.o_done), 0);
        chk("abort_readadd", int'(bus.o_readAdd), 0);
        chk("abort_data", int'(bus.o_data), 0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("abort_no_done", done_n, 0);
        chk("abort_no_more_beats", got.size(), 2);
        run_burst(0, 2, 0, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
